// File: rtl/sprite_table_writer.sv
// Sprite table writer: mirrors player/obstacle positions into a BRAM table
// and maintains a high-water sprite_count word at BASE_ADDR.
//
// state  | meaning
// INIT   | zero words BASE_ADDR..BASE_ADDR+2*MAX_SPRITES, one per cycle
// IDLE   | ready for a position update
// WR_X   | write clamped X of the latched slot
// WR_Y   | write clamped Y of the latched slot
// WR_CNT | publish a grown sprite_count

module sprite_table_writer #(
    parameter int MAX_SPRITES = 16,
    parameter int BASE_ADDR   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [4:0]  upd_index,
    input  logic [9:0]  upd_x,
    input  logic [9:0]  upd_y,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] sprite_count,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        WR_X   = 3'd2,
        WR_Y   = 3'd3,
        WR_CNT = 3'd4
    } state_t;

    localparam logic [9:0] BASE      = 10'(BASE_ADDR);
    localparam logic [9:0] INIT_LAST = 10'(2 * MAX_SPRITES);
    localparam logic [5:0] SLOTS     = 6'(MAX_SPRITES);

    state_t      state_q, state_d;
    logic [9:0]  init_off_q, init_off_d;
    logic [4:0]  idx_q, idx_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;

    logic        in_range;
    logic        is_player;
    logic [9:0]  x_lim, y_lim;
    logic [9:0]  x_clamped, y_clamped;
    logic [9:0]  slot_addr;
    logic [15:0] idx_plus1;
    logic        ready_int;

    assign in_range  = {1'b0, upd_index} < SLOTS;
    assign is_player = (upd_index == 5'd0);

    // The player sprite is 32 px wide, obstacles 16 px; keep them on the 640x480 screen.
    assign x_lim     = is_player ? 10'd608 : 10'd624;
    assign y_lim     = is_player ? 10'd448 : 10'd464;
    assign x_clamped = (upd_x > x_lim) ? x_lim : upd_x;
    assign y_clamped = (upd_y > y_lim) ? y_lim : upd_y;

    assign slot_addr = BASE + 10'd1 + {4'd0, idx_q, 1'b0};
    assign idx_plus1 = 16'(idx_q) + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_off_q <= '0;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_off_q <= init_off_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_off_d = init_off_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        count_d    = count_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = BASE;
        wr_data    = '0;
        ready_int  = 1'b0;

        case (state_q)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = BASE + init_off_q;
                if (init_off_q == INIT_LAST) begin
                    init_off_d = '0;
                    state_d    = IDLE;
                end else begin
                    init_off_d = init_off_q + 10'd1;
                end
            end
            IDLE: begin
                ready_int = 1'b1;
                if (upd_valid) begin
                    if (in_range) begin
                        idx_d   = upd_index;
                        x_d     = x_clamped;
                        y_d     = y_clamped;
                        state_d = WR_X;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_X: begin
                wr_en   = 1'b1;
                wr_addr = slot_addr;
                wr_data = {6'd0, x_q};
                state_d = WR_Y;
            end
            WR_Y: begin
                wr_en   = 1'b1;
                wr_addr = slot_addr + 10'd1;
                wr_data = {6'd0, y_q};
                state_d = (idx_plus1 > count_q) ? WR_CNT : IDLE;
            end
            WR_CNT: begin
                wr_en   = 1'b1;
                wr_addr = BASE;
                wr_data = idx_plus1;
                count_d = idx_plus1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Reset is synchronous, but no strobe or handshake may escape while it is held.
        if (reset) begin
            wr_en     = 1'b0;
            ready_int = 1'b0;
        end
    end

    assign upd_ready    = ready_int;
    assign busy         = reset | (state_q != IDLE);
    assign err          = err_q & ~reset;
    assign sprite_count = count_q;

endmodule

// File: tb/tb_sprite_table_writer.sv
// Randomized bench for sprite_table_writer: a table-level model predicts the
// ordered write stream, handshake, err pulses and published count.

module tb_sprite_table_writer;

    localparam int MAX  = 16;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [4:0]  upd_index = '0;
    logic [9:0]  upd_x = '0;
    logic [9:0]  upd_y = '0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] sprite_count;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected write stream, each entry {addr, data}.
    logic [25:0] exp_q[$];
    int          model_cnt   = 0;
    bit          err_pending = 1'b0;
    bit          prev_reset  = 1'b0;

    sprite_table_writer #(.MAX_SPRITES(MAX), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_index(upd_index), .upd_x(upd_x), .upd_y(upd_y),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sprite_count(sprite_count), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Model: predicts each accepted update from the table rules, then scores the DUT every cycle.
    always @(negedge clk) begin
        logic [25:0] e;
        int          w, mx, my, a;
        bit          exp_ready;
        if (reset) begin
            exp_q.delete();
            model_cnt   = 0;
            err_pending = 1'b0;
            check_eq("rst_wr_en", wr_en, 0);
            check_eq("rst_ready", upd_ready, 0);
            check_eq("rst_busy", busy, 1);
            check_eq("rst_err", err, 0);
            if (prev_reset) check_eq("rst_count", sprite_count, 0);
            prev_reset = 1'b1;
        end else begin
            if (prev_reset)
                for (int i = 0; i <= 2 * MAX; i++) exp_q.push_back({10'(BASE + i), 16'd0});
            prev_reset = 1'b0;

            exp_ready = (exp_q.size() == 0);
            check_eq("upd_ready", upd_ready, exp_ready);
            check_eq("busy", busy, !exp_ready);
            check_eq("err", err, err_pending);
            err_pending = 1'b0;
            if (exp_ready) check_eq("sprite_count", sprite_count, model_cnt);

            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_wr", wr_en, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", wr_addr, e[25:16]);
                    check_eq("wr_data", wr_data, e[15:0]);
                end
            end else if (exp_q.size() != 0) begin
                check_eq("missing_wr", wr_en, 1);
            end

            if (upd_valid && upd_ready) begin
                if (int'(upd_index) >= MAX) begin
                    err_pending = 1'b1;
                end else begin
                    w  = (upd_index == 0) ? 32 : 16;
                    mx = (int'(upd_x) > 640 - w) ? 640 - w : int'(upd_x);
                    my = (int'(upd_y) > 480 - w) ? 480 - w : int'(upd_y);
                    a  = (BASE + 1 + 2 * int'(upd_index)) % 1024;
                    exp_q.push_back({10'(a), 16'(mx)});
                    exp_q.push_back({10'((a + 1) % 1024), 16'(my)});
                    if (int'(upd_index) + 1 > model_cnt) begin
                        model_cnt = int'(upd_index) + 1;
                        exp_q.push_back({10'(BASE), 16'(model_cnt)});
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (upd_ready) break;
        end
        check_eq("idle_reached", upd_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Offer one update; returns just after the accepting edge. hold keeps upd_valid high.
    task automatic send(input int idx, input int x, input int y, input bit hold);
        upd_index = 5'(idx);
        upd_x     = 10'(x);
        upd_y     = 10'(y);
        upd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (upd_ready) break;
        end
        if (!upd_ready) check_eq("accept_timeout", upd_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) upd_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_idle();

        send(0, 100, 50, 0);
        wait_idle();
        send(3, 700, 470, 0);
        wait_idle();
        send(1, 5, 6, 0);
        wait_idle();
        send(20, 9, 9, 0);
        repeat (2) begin @(posedge clk); #1; end

        // Valid held across three back-to-back updates.
        send(7, 1023, 0, 1);
        send(0, 640, 479, 1);
        send(15, 300, 200, 1);
        upd_valid = 1'b0;
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                upd_index = 5'($urandom_range(0, 31));
                upd_x     = 10'($urandom_range(0, 1023));
                @(posedge clk);
                #1;
            end
            send($urandom_range(0, 23), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 bit'($urandom_range(0, 1)));
        end
        upd_valid = 1'b0;
        wait_idle();

        // Reset in the middle of INIT, then in the middle of a WR_Y.
        do_reset(2);
        repeat (10) begin @(posedge clk); #1; end
        do_reset(2);
        wait_idle();
        send(9, 40, 30, 0);
        wait_idle();
        send(12, 50, 60, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_idle();
        send(2, 11, 22, 0);
        wait_idle();

        @(posedge clk);
        check_eq("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
